// File: rtl/cache_arbiter_rr.sv
// rtl/cache_arbiter_rr.sv - N-port cacheline request arbiter onto one downstream line port
//
// Merges line read/write requests from NUM_PORTS upstream caches onto a single
// downstream port, one transaction at a time. Arbitration is round-robin
// (ROUND_ROBIN=1) or fixed priority with port 0 highest (ROUND_ROBIN=0).
// Every output comes straight from a flop.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   port_read/port_write      per-port request bits, held until that port's resp
//   port_address/port_wdata   packed per-port address / write line (port i at i*W)
//   port_rdata                last captured read line, broadcast to all ports
//   port_resp                 one-hot, one-cycle completion pulse
//   mem_read/mem_write        downstream request, held for the whole transaction
//   mem_address/mem_wdata     downstream address / write line, held stable
//   mem_rdata/mem_resp        downstream read line and one-cycle completion
//   grant                     one-hot owner of the current transaction, 0 when idle

module cache_arbiter_rr #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        port_read,
    input  logic [NUM_PORTS-1:0]        port_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_address,
    input  logic [NUM_PORTS*LINE_W-1:0] port_wdata,
    output logic [LINE_W-1:0]           port_rdata,
    output logic [NUM_PORTS-1:0]        port_resp,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic [LINE_W-1:0]           mem_rdata,
    input  logic                        mem_resp,
    output logic [NUM_PORTS-1:0]        grant
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [NUM_PORTS-1:0] ONE_HOT_0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(NUM_PORTS - 1);

    logic [1:0]           state_q,       state_d;
    logic [PTR_W-1:0]     ptr_q,         ptr_d;
    logic [NUM_PORTS-1:0] grant_q,       grant_d;
    logic [NUM_PORTS-1:0] port_resp_q,   port_resp_d;
    logic                 mem_read_q,    mem_read_d;
    logic                 mem_write_q,   mem_write_d;
    logic [ADDR_W-1:0]    mem_address_q, mem_address_d;
    logic [LINE_W-1:0]    mem_wdata_q,   mem_wdata_d;
    logic [LINE_W-1:0]    port_rdata_q,  port_rdata_d;

    logic [NUM_PORTS-1:0] req;
    logic [PTR_W-1:0]     scan_base;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_valid;
    logic [PTR_W-1:0]     ptr_after_win;

    assign req = port_read | port_write;

    // Index base+k folded back into 0..NUM_PORTS-1; handles non power-of-two counts.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_PORTS) begin
            s = s - NUM_PORTS;
        end
        return PTR_W'(s);
    endfunction

    // Fixed priority is the round-robin scan with its start pinned at port 0.
    assign scan_base = (ROUND_ROBIN != 0) ? ptr_q : '0;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!win_valid && req[wrap_add(scan_base, k)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_add(scan_base, k);
            end
        end
    end

    assign ptr_after_win = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        port_resp_d   = port_resp_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        port_rdata_d  = port_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d       = ONE_HOT_0 << win_idx;
                    // Read+write on the same port is a write.
                    mem_write_d   = port_write[win_idx];
                    mem_read_d    = ~port_write[win_idx];
                    mem_address_d = port_address[int'(win_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_d   = port_wdata[int'(win_idx)*LINE_W +: LINE_W];
                    if (ROUND_ROBIN != 0) begin
                        ptr_d = ptr_after_win;
                    end
                    state_d       = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Upstream inputs are not looked at here; the latched copies drive mem_*.
                if (mem_resp) begin
                    if (mem_read_q) begin
                        port_rdata_d = mem_rdata;
                    end
                    port_resp_d = grant_q;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                // One dead cycle lets the requester drop its request before
                // arbitration runs again, so it can never be granted twice.
                port_resp_d = '0;
                grant_d     = '0;
                state_d     = ST_IDLE;
            end

            default: begin
                port_resp_d = '0;
                grant_d     = '0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            port_resp_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            port_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            port_resp_q   <= port_resp_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            port_rdata_q  <= port_rdata_d;
        end
    end

    assign grant       = grant_q;
    assign port_resp   = port_resp_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign port_rdata  = port_rdata_q;

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// tb/tb_cache_arbiter_rr.sv - self-checking bench for cache_arbiter_rr

module tb_cache_arbiter_rr;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic [3:0]    rd = '0;
    logic [3:0]    wr = '0;
    logic [AW-1:0] pa [4];
    logic [LW-1:0] wd [4];
    logic [LW-1:0] dn_line = '0;
    int            lat = 1;
    int            tgt = 0;

    logic [4*AW-1:0] pa_flat;
    logic [4*LW-1:0] wd_flat;
    assign pa_flat = {pa[3], pa[2], pa[1], pa[0]};
    assign wd_flat = {wd[3], wd[2], wd[1], wd[0]};

    // a: 2 ports round-robin, b: 2 ports fixed priority, c: 4 ports round-robin
    logic [1:0]    a_grant, a_resp, b_grant, b_resp;
    logic [3:0]    c_grant, c_resp;
    logic          a_mrd, a_mwr, b_mrd, b_mwr, c_mrd, c_mwr;
    logic [AW-1:0] a_maddr, b_maddr, c_maddr;
    logic [LW-1:0] a_mwd, b_mwd, c_mwd, a_rdata, b_rdata, c_rdata;
    logic          a_mresp, b_mresp, c_mresp;
    int            a_cnt, b_cnt, c_cnt;

    cache_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .ROUND_ROBIN(1)) u_a (
        .clk(clk), .reset_n(reset_n), .port_read(rd[1:0]), .port_write(wr[1:0]),
        .port_address(pa_flat[2*AW-1:0]), .port_wdata(wd_flat[2*LW-1:0]),
        .port_rdata(a_rdata), .port_resp(a_resp), .mem_read(a_mrd), .mem_write(a_mwr),
        .mem_address(a_maddr), .mem_wdata(a_mwd), .mem_rdata(dn_line), .mem_resp(a_mresp),
        .grant(a_grant));

    cache_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .ROUND_ROBIN(0)) u_b (
        .clk(clk), .reset_n(reset_n), .port_read(rd[1:0]), .port_write(wr[1:0]),
        .port_address(pa_flat[2*AW-1:0]), .port_wdata(wd_flat[2*LW-1:0]),
        .port_rdata(b_rdata), .port_resp(b_resp), .mem_read(b_mrd), .mem_write(b_mwr),
        .mem_address(b_maddr), .mem_wdata(b_mwd), .mem_rdata(dn_line), .mem_resp(b_mresp),
        .grant(b_grant));

    cache_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW), .ROUND_ROBIN(1)) u_c (
        .clk(clk), .reset_n(reset_n), .port_read(rd), .port_write(wr),
        .port_address(pa_flat), .port_wdata(wd_flat),
        .port_rdata(c_rdata), .port_resp(c_resp), .mem_read(c_mrd), .mem_write(c_mwr),
        .mem_address(c_maddr), .mem_wdata(c_mwd), .mem_rdata(dn_line), .mem_resp(c_mresp),
        .grant(c_grant));

    // View of the instance under test.
    logic [3:0]    grant_v, resp_v;
    logic          mrd_v, mwr_v;
    logic [AW-1:0] maddr_v;
    logic [LW-1:0] mwd_v, rdata_v;
    always_comb begin
        grant_v = c_grant; resp_v = c_resp; mrd_v = c_mrd; mwr_v = c_mwr;
        maddr_v = c_maddr; mwd_v = c_mwd; rdata_v = c_rdata;
        if (tgt == 0) begin
            grant_v = {2'b00, a_grant}; resp_v = {2'b00, a_resp}; mrd_v = a_mrd; mwr_v = a_mwr;
            maddr_v = a_maddr; mwd_v = a_mwd; rdata_v = a_rdata;
        end else if (tgt == 1) begin
            grant_v = {2'b00, b_grant}; resp_v = {2'b00, b_resp}; mrd_v = b_mrd; mwr_v = b_mwr;
            maddr_v = b_maddr; mwd_v = b_mwd; rdata_v = b_rdata;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Downstream model: answers `lat` cycles after the request appears.
    task automatic resp_step(input logic active, input logic cur, input int cnt_i,
                             output logic nxt, output int cnt_o);
        nxt = 1'b0;
        cnt_o = 0;
        if (reset_n && !cur && active) begin
            cnt_o = cnt_i + 1;
            if (cnt_o >= lat) nxt = 1'b1;
        end
    endtask

    initial begin
        a_mresp = 1'b0; a_cnt = 0;
        forever begin
            @(negedge clk);
            resp_step(a_mrd | a_mwr, a_mresp, a_cnt, a_mresp, a_cnt);
        end
    end
    initial begin
        b_mresp = 1'b0; b_cnt = 0;
        forever begin
            @(negedge clk);
            resp_step(b_mrd | b_mwr, b_mresp, b_cnt, b_mresp, b_cnt);
        end
    end
    initial begin
        c_mresp = 1'b0; c_cnt = 0;
        forever begin
            @(negedge clk);
            resp_step(c_mrd | c_mwr, c_mresp, c_cnt, c_mresp, c_cnt);
        end
    end

    // Scoreboard
    typedef struct {
        logic [3:0]    resp;
        logic [AW-1:0] addr;
        logic          is_wr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            lat;
    } exp_t;

    exp_t          sb [$];
    logic [LW-1:0] model_rdata = '0;

    task automatic push(input logic [3:0] g, input logic is_wr, input int l);
        exp_t e;
        int idx = 0;
        for (int p = 0; p < 4; p++) if (g[p]) idx = p;
        e.resp  = g;
        e.addr  = pa[idx];
        e.is_wr = is_wr;
        e.wdata = wd[idx];
        if (!is_wr) model_rdata = dn_line;
        e.rdata = model_rdata;
        e.lat   = l;
        sb.push_back(e);
    endtask

    logic [3:0]    pg = '0, cap_g = '0;
    logic          cap_rd = 1'b0, cap_wr = 1'b0;
    logic [AW-1:0] cap_a = '0;
    logic [LW-1:0] cap_wd = '0;
    int            busy = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (grant_v != 4'b0 && pg == 4'b0) begin
                    cap_g = grant_v; cap_a = maddr_v; cap_rd = mrd_v; cap_wr = mwr_v;
                    cap_wd = mwd_v; busy = 0;
                end
                if (mrd_v | mwr_v) busy++;
                if (resp_v != 4'b0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", resp_v, 4'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("port_resp", resp_v, e.resp);
                        chk("grant_owner", cap_g, e.resp);
                        chk("mem_address", cap_a, e.addr);
                        chk("mem_write", cap_wr, e.is_wr);
                        chk("mem_read", cap_rd, !e.is_wr);
                        if (e.is_wr) chk("mem_wdata", cap_wd, e.wdata);
                        chk("port_rdata", rdata_v, e.rdata);
                        chk("busy_cycles", busy, e.lat);
                    end
                end
            end
            pg = reset_n ? grant_v : 4'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        rd = '0;
        wr = '0;
        @(negedge clk);
        chk("rst_grant", grant_v, 4'b0);
        chk("rst_port_resp", resp_v, 4'b0);
        chk("rst_mem_read", mrd_v, 1'b0);
        chk("rst_mem_write", mwr_v, 1'b0);
        chk("rst_mem_address", maddr_v, '0);
        chk("rst_mem_wdata", mwd_v, '0);
        chk("rst_port_rdata", rdata_v, '0);
        sb.delete();
        model_rdata = '0;
        reset_n = 1'b1;
    endtask

    task automatic wait_resp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_v == 4'b0 && n < 100);
        checks++;
        if (resp_v == 4'b0) begin
            failures++;
            $display("FAIL resp_timeout actual=none required=port_resp within 100 cycles");
        end
    endtask

    task automatic after_resp();
        rd = '0;
        wr = '0;
        @(negedge clk);
        chk("resp_one_cycle", resp_v, 4'b0);
        chk("grant_clear", grant_v, 4'b0);
    endtask

    typedef struct {
        int            tgt;
        logic [3:0]    rd;
        logic [3:0]    wr;
        int            lat;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        logic [3:0]    g;
        logic          is_wr;
    } vec_t;

    vec_t vt [13];

    initial begin
        for (int p = 0; p < 4; p++) begin
            pa[p] = '0;
            wd[p] = '0;
        end

        vt[0]  = '{0, 4'b0001, 4'b0000, 4, 32'h0000_1000, {32{8'hA5}},     4'b0001, 1'b0};
        vt[1]  = '{0, 4'b0011, 4'b0000, 2, 32'h2000_0000, {32{8'h3C}},     4'b0010, 1'b0};
        vt[2]  = '{0, 4'b0011, 4'b0000, 2, 32'h2000_0400, {16{16'hBEEF}},  4'b0001, 1'b0};
        vt[3]  = '{0, 4'b0000, 4'b0010, 1, 32'h4000_0000, {32{8'h5A}},     4'b0010, 1'b1};
        vt[4]  = '{0, 4'b0011, 4'b0010, 3, 32'h5000_0000, {32{8'h11}},     4'b0001, 1'b0};
        vt[5]  = '{0, 4'b0011, 4'b0010, 1, 32'h5000_1000, {32{8'h22}},     4'b0010, 1'b1};
        vt[6]  = '{1, 4'b0011, 4'b0000, 2, 32'h6000_0000, {32{8'h33}},     4'b0001, 1'b0};
        vt[7]  = '{1, 4'b0011, 4'b0000, 1, 32'h6000_1000, {32{8'h44}},     4'b0001, 1'b0};
        vt[8]  = '{1, 4'b0010, 4'b0000, 2, 32'h6000_2000, {32{8'h55}},     4'b0010, 1'b0};
        vt[9]  = '{2, 4'b0100, 4'b0000, 2, 32'h7000_0000, {32{8'h66}},     4'b0100, 1'b0};
        vt[10] = '{2, 4'b1001, 4'b0000, 1, 32'h7000_1000, {32{8'h77}},     4'b1000, 1'b0};
        vt[11] = '{2, 4'b1001, 4'b0000, 2, 32'h7000_2000, {32{8'h88}},     4'b0001, 1'b0};
        vt[12] = '{2, 4'b1010, 4'b0000, 1, 32'h7000_3000, {32{8'h99}},     4'b0010, 1'b0};

        for (int i = 0; i < 13; i++) begin
            if (i == 0 || vt[i].tgt != vt[i-1].tgt) begin
                tgt = vt[i].tgt;
                do_reset();
            end
            lat = vt[i].lat;
            dn_line = vt[i].line;
            for (int p = 0; p < 4; p++) begin
                pa[p] = vt[i].addr + 32'(p) * 32'h100;
                wd[p] = {8{32'h1234_5678 ^ 32'(i * 16 + p)}};
            end
            push(vt[i].g, vt[i].is_wr, vt[i].lat);
            rd = vt[i].rd;
            wr = vt[i].wr;
            @(negedge clk);
            chk("grant_latency", grant_v, vt[i].g);
            wait_resp();
            after_resp();
        end

        // Round-robin fairness with both ports holding reads continuously.
        tgt = 0;
        do_reset();
        lat = 2;
        dn_line = {8{32'hCAFE_0001}};
        pa[0] = 32'h0000_2000;
        pa[1] = 32'h0000_3000;
        push(4'b0001, 1'b0, 2);
        push(4'b0010, 1'b0, 2);
        push(4'b0001, 1'b0, 2);
        push(4'b0010, 1'b0, 2);
        rd = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            wait_resp();
            @(negedge clk);
            chk("rr_resp_one_cycle", resp_v, 4'b0);
        end
        rd = '0;
        @(negedge clk);

        // Fixed priority: port0 keeps winning until it lets go.
        tgt = 1;
        do_reset();
        lat = 1;
        dn_line = {8{32'hF00D_0002}};
        push(4'b0001, 1'b0, 1);
        push(4'b0001, 1'b0, 1);
        push(4'b0001, 1'b0, 1);
        push(4'b0010, 1'b0, 1);
        rd = 4'b0011;
        for (int t = 0; t < 3; t++) begin
            wait_resp();
            if (t == 2) rd = 4'b0010;
            @(negedge clk);
        end
        wait_resp();
        after_resp();

        // Write held stable while the upstream address and data move.
        tgt = 0;
        do_reset();
        lat = 1;
        dn_line = {32{8'hA5}};
        pa[0] = 32'h0000_1000;
        push(4'b0001, 1'b0, 1);
        rd = 4'b0001;
        wait_resp();
        after_resp();
        pa[1] = 32'h8000_0020;
        wd[1] = {16{16'h1234}};
        lat = 5;
        push(4'b0010, 1'b1, 5);
        wr = 4'b0010;
        repeat (3) @(negedge clk);
        pa[1] = 32'hDEAD_BEEF;
        wd[1] = {16{16'hFFFF}};
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            chk("hold_mem_address", maddr_v, 32'h8000_0020);
            chk("hold_mem_wdata", mwd_v, {16{16'h1234}});
            chk("hold_mem_write", mwr_v, 1'b1);
        end
        wait_resp();
        after_resp();

        // Reset in the middle of a transaction with the pointer at port 1.
        tgt = 0;
        do_reset();
        lat = 1;
        dn_line = {8{32'h0BAD_F00D}};
        pa[0] = 32'h0000_4000;
        pa[1] = 32'h0000_5000;
        push(4'b0001, 1'b0, 1);
        rd = 4'b0001;
        wait_resp();
        after_resp();
        lat = 20;
        rd = 4'b0010;
        repeat (3) @(negedge clk);
        chk("mid_busy_mem_read", mrd_v, 1'b1);
        chk("mid_busy_grant", grant_v, 4'b0010);
        do_reset();
        lat = 1;
        push(4'b0001, 1'b0, 1);
        rd = 4'b0011;
        @(negedge clk);
        chk("post_reset_winner", grant_v, 4'b0001);
        wait_resp();
        after_resp();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_arbiter_rr.md
# cache_arbiter_rr

Parametrised N-port arbiter that merges cacheline-granularity read/write requests from `NUM_PORTS` upstream caches (icache, dcache, future prefetcher/L2 victim paths) onto one downstream line port feeding the L2 cache or the cacheline adapter. It replaces the fixed two-port instruction/data arbiter. It adds:

- selectable round-robin or fixed-priority arbitration;
- registered, held-stable downstream signals;
- a one-hot, one-cycle response to the winning port.

## Interface

Parameters:
- `NUM_PORTS`, 2, number of upstream requesters (≥2).
- `ADDR_W`, 32, address width.
- `LINE_W`, 256, cacheline width.
- `ROUND_ROBIN`, 1, 1 = rotating priority; 0 = fixed priority, port 0 highest.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `port_read`  in  NUM_PORTS  per-port line read request, held until that port's resp.
- `port_write`  in  NUM_PORTS  per-port line write request, held until that port's resp.
- `port_address`  in  NUM_PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W].
- `port_wdata`  in  NUM_PORTS*LINE_W  port i at [i*LINE_W +: LINE_W].
- `port_rdata`  out  LINE_W  captured read line, broadcast to all ports.
- `port_resp`  out  NUM_PORTS  one-hot completion pulse.
- `mem_read` / `mem_write`  out  1  downstream request.
- `mem_address`  out  ADDR_W  downstream address.
- `mem_wdata`  out  LINE_W  downstream write line.
- `mem_rdata`  in  LINE_W  downstream read line, valid with `mem_resp`.
- `mem_resp`  in  1  downstream completion, one cycle.
- `grant`  out  NUM_PORTS  one-hot owner of current transaction; 0 when idle.

## Operation

- Request vector: `req[i] = port_read[i] | port_write[i]`.
- A port asserting both read and write is treated as a write.
- FSM states:
  - IDLE:
    - If any `req` is set, select winner g, latch op/address/wdata of g into registers, set `grant`=1<<g, then go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - Registered `mem_read`/`mem_write`/`mem_address`/`mem_wdata` are driven from the latched values and held constant.
    - On `mem_resp`: capture `mem_rdata` into `port_rdata` (reads only; writes leave `port_rdata` unchanged), set `port_resp`=1<<g, then go to RESP.
  - RESP:
    - `port_resp` is high for exactly this cycle.
    - `mem_read`/`mem_write` are 0.
    - Go to IDLE unconditionally.
    - `grant` clears on exit.
- Winner selection:
  - `ROUND_ROBIN`=1: pointer p (log2 NUM_PORTS bits, reset 0). The winner is the first requesting index scanning p, p+1, … wrapping modulo NUM_PORTS. On grant, p ← (g+1) mod NUM_PORTS.
  - `ROUND_ROBIN`=0: lowest requesting index wins; p is unused.
- Upstream changes to address, wdata or request during BUSY/RESP are ignored. A dropped request does not abort the transaction; it completes and the port still receives `port_resp`.
- Only one downstream transaction is outstanding at any time.
- Reset values:
  - state IDLE, p=0.
  - `grant`, `port_resp`, `mem_read`, `mem_write` = 0.
  - `mem_address`, `mem_wdata`, `port_rdata` = 0.
- Reset mid-transaction abandons the transaction: all outputs take reset values on the next edge. The downstream block is reset by the same `reset_n`.

## Timing

- Request seen in IDLE at edge 0 → `grant`, `mem_read`/`mem_write` high after edge 0 (1-cycle arbitration latency).
- `mem_resp` sampled high at edge k → `port_resp`/`port_rdata` valid after edge k; IDLE after edge k+1. The earliest next grant is at edge k+2.
- Minimum cost of a transaction with a 1-cycle downstream: 3 cycles from request to IDLE.
- No combinational path from any input to any output; all outputs are registered.
- `mem_resp` outside BUSY is ignored.
- A requester seeing `port_resp` must deassert its request on the following cycle. The RESP cycle guarantees that request is never re-granted.

## Test plan

- **Single read:** NUM_PORTS=2; port0 reads 0x0000_1000; downstream answers after 4 cycles with line 0xA5…A5 → `mem_read` high for exactly 4 cycles; `port_resp`=2'b01 for 1 cycle; `port_rdata`=0xA5…A5; port1 sees no resp.
- **Round-robin fairness:** both ports hold reads continuously, 2-cycle downstream → grant order 0,1,0,1; no port granted twice in a row; `port_resp` alternates 01,10.
- **Fixed priority:** `ROUND_ROBIN`=0, both requesting → port0 wins every arbitration while it keeps requesting; port1 is granted only after port0 deasserts.
- **Write with stable signals:** port1 writes 0x8000_0020, line 0x1234…; upstream address changes to 0xDEAD_BEEF mid-BUSY → `mem_address` stays 0x8000_0020 and `mem_wdata` is unchanged until `mem_resp`; `port_resp`=2'b10; `port_rdata` unchanged.
- **Reset mid-transaction:** `reset_n` low during BUSY → next cycle `mem_read`=0, `grant`=0, p=0. After release with both ports requesting, port0 wins first.
- **N=4 wrap:** NUM_PORTS=4; ports 3 and 0 requesting; p=3 → grant 3, then 0, pointer wraps to 1.
